// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: instruction-step FSM, condition check
// and NZCV flag register, with control signals decoded from the current step.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state_r;
  logic [3:0] flags_r;
  logic       condex_s;
  logic       wb_pc_s;
  logic       cmd_arith_s;

  // Condition field against NZCV; 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = ~cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cy & ~z;
      4'b1001: cond_eval = ~cy | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = 2'b00;
      4'b0010: alu_decode = 2'b01;
      4'b0000: alu_decode = 2'b10;
      4'b1100: alu_decode = 2'b11;
      default: alu_decode = 2'b00;
    endcase
  endfunction

  assign condex_s    = cond_eval(Cond, flags_r);
  assign wb_pc_s     = (Rd == 4'd15);
  assign cmd_arith_s = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010);
  assign Flags       = flags_r;
  assign State       = state_r;

  // Step sequencing and NZCV capture at the end of a flag-setting execute step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
      flags_r <= 4'b0000;
    end else begin
      case (state_r)
        FETCH:   state_r <= DECODE;
        DECODE: begin
          case (Op)
            2'b00:   state_r <= Funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   state_r <= MEMADR;
            2'b10:   state_r <= BRANCH;
            default: state_r <= FETCH;
          endcase
        end
        MEMADR:  state_r <= Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD: state_r <= MEMWB;
        EXECUTER, EXECUTEI: begin
          state_r <= ALUWB;
          // Logical ops leave C and V alone.
          if (Funct[0] && condex_s) begin
            flags_r[3:2] <= ALUFlags[3:2];
            if (cmd_arith_s) begin
              flags_r[1:0] <= ALUFlags[1:0];
            end else begin
              flags_r[1:0] <= flags_r[1:0];
            end
          end else begin
            flags_r <= flags_r;
          end
        end
        MEMWB, MEMWRITE, ALUWB, BRANCH: state_r <= FETCH;
        default: state_r <= FETCH;
      endcase
    end
  end

  // Control decode for the current step; reset holds the FETCH decoding.
  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = Op;
    RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    case (state_r)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_s;
      end
      MEMWB, ALUWB: begin
        ResultSrc = (state_r == MEMWB) ? 2'b01 : 2'b00;
        if (wb_pc_s) begin
          PCWrite = condex_s;
        end else begin
          RegWrite = condex_s;
        end
      end
      EXECUTER: begin
        ALUControl = alu_decode(Funct[4:1]);
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(Funct[4:1]);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex_s;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction scenarios plus random
// instructions checked step by step against an instruction-level model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags, State;
  logic [15:0] ctrl;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] mflags;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Flags(Flags), .State(State)
  );

  assign ctrl = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                 ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Odd condition codes are the inverse of the even code below them.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic [7:0] base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = {1'b1, (~z & (n == v)), (n == v), (cy & ~z), v, n, cy, z};
    return base[c[3:1]] ^ c[0];
  endfunction

  function automatic logic [1:0] ref_alu(input logic [3:0] cmd);
    if (cmd == 4'd4) return 2'd0;
    if (cmd == 4'd2) return 2'd1;
    if (cmd == 4'd0) return 2'd2;
    if (cmd == 4'd12) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [15:0] exp_ctrl(input int st, input logic [1:0] op,
                                           input logic [5:0] funct, input logic [3:0] rd,
                                           input logic ce);
    logic pcw, mw, rw, irw, adr, asa;
    logic [1:0] rs, bs, alc;
    pcw = 1'b0; mw = 1'b0; rw = 1'b0; irw = 1'b0; adr = 1'b0; asa = 1'b0;
    rs = 2'b00; bs = 2'b00; alc = 2'b00;
    if (st == 0) begin irw = 1'b1; pcw = 1'b1; asa = 1'b1; bs = 2'b10; rs = 2'b10; end
    if (st == 1) begin asa = 1'b1; bs = 2'b10; rs = 2'b10; end
    if (st == 2) bs = 2'b01;
    if (st == 3) adr = 1'b1;
    if (st == 4) rs = 2'b01;
    if (st == 5) begin adr = 1'b1; mw = ce; end
    if (st == 6) alc = ref_alu(funct[4:1]);
    if (st == 7) begin bs = 2'b01; alc = ref_alu(funct[4:1]); end
    if (st == 4 || st == 8) begin
      if (rd == 4'd15) pcw = ce;
      else rw = ce;
    end
    if (st == 9) begin bs = 2'b01; rs = 2'b10; pcw = ce; end
    return {pcw, mw, rw, irw, adr, asa, rs, bs, op, (op == 2'b01), (op == 2'b10), alc};
  endfunction

  // Entered at a falling edge with the DUT in FETCH; nsteps=0 runs the whole instruction.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] af, input int nsteps);
    int seq[$];
    logic ce;
    Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = af;
    seq = {0, 1};
    if (op == 2'b00) begin
      seq.push_back(funct[5] ? 7 : 6);
      seq.push_back(8);
    end else if (op == 2'b01) begin
      seq.push_back(2);
      if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
      else seq.push_back(5);
    end else if (op == 2'b10) begin
      seq.push_back(9);
    end
    for (int i = 0; i < seq.size() && (nsteps == 0 || i < nsteps); i++) begin
      #1;
      ce = ref_cond(cond, mflags);
      chk($sformatf("state@step%0d", i), State, seq[i]);
      chk($sformatf("flags@st%0d", seq[i]), Flags, mflags);
      chk($sformatf("ctrl@st%0d", seq[i]), ctrl, exp_ctrl(seq[i], op, funct, rd, ce));
      if ((seq[i] == 6 || seq[i] == 7) && funct[0] && ce) begin
        mflags[3:2] = af[3:2];
        if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010) mflags[1:0] = af[1:0];
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; Cond = 4'b0000; Op = 2'b00; Funct = 6'b000000; Rd = 4'd0; ALUFlags = 4'b0000;
    mflags = 4'b0000;
    #1;
    chk("reset_state", State, 4'd0);
    chk("reset_flags", Flags, 4'b0000);
    @(posedge clk);
    #1;
    chk("reset_ctrl", ctrl, exp_ctrl(0, 2'b00, 6'b000000, 4'd0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(4'b1110, 2'b00, 6'b011001, 4'd2, 4'b1011, 0);   // ORRS
    chk("orrs_flags", Flags, 4'b1000);
    run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, 0);   // Op=11
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd3, 4'b0101, 0);   // ADD reg
    run_instr(4'b1110, 2'b01, 6'b000001, 4'd15, 4'b0000, 0);  // LDR pc
    run_instr(4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0110, 0);   // SUBS
    chk("subs_flags", Flags, 4'b0110);
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000, 0);   // BEQ
    run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000, 0);   // BNE
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd4, 4'b1111, 0);   // ADDS
    chk("adds_flags", Flags, 4'b1111);
    run_instr(4'b1000, 2'b01, 6'b000000, 4'd5, 4'b0000, 0);   // STR HI
    run_instr(4'b1101, 2'b01, 6'b000000, 4'd5, 4'b0000, 0);   // STR LE
    run_instr(4'b1110, 2'b01, 6'b000001, 4'd6, 4'b0000, 3);   // LDR stopped in MEMREAD
    #1;
    chk("pre_reset_state", State, 4'd3);
    rst_n = 1'b0;
    #1;
    mflags = 4'b0000;
    chk("async_reset_state", State, 4'd0);
    chk("async_reset_flags", Flags, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 300; k++) begin
      run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                6'($urandom_range(0, 63)),
                ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                4'($urandom_range(0, 15)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
